// File: rtl/addsub_sched.sv
// addsub_sched: round-robin scheduler sharing one pipelined add/sub datapath
// among N_REQ requesters. Issued operations are tracked by a tag pipeline so
// each result is routed back to its owner in issue order. A flush request
// stops issuing and drains the datapath, ending with a one-cycle flush_done.
// Optional feature: define ADDSUB_SCHED_STATS_EN to build saturating
// per-requester grant counters on stat_grants (constant 0 otherwise).
`timescale 1ns/1ps

module addsub_sched #(
  parameter int N_REQ  = 4,
  parameter int IN_WL  = 15,
  parameter int OUT_WL = 16,
  parameter int DP_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*IN_WL-1:0]  req_a,
  input  logic [N_REQ*IN_WL-1:0]  req_b,
  input  logic [N_REQ-1:0]        req_add_nsub,
  output logic [IN_WL-1:0]        dp_a,
  output logic [IN_WL-1:0]        dp_b,
  output logic                    dp_add_nsub,
  input  logic [OUT_WL-1:0]       dp_r,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [OUT_WL-1:0]       rsp_data,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    busy,
  output logic [N_REQ*16-1:0]     stat_grants
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         drained_q, drained_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic [DP_LAT:0]              tag_v_q, tag_v_d;
  logic [DP_LAT:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic [IN_WL-1:0]             dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic                         dp_op_q, dp_op_d;
  logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [OUT_WL-1:0]            rsp_data_q, rsp_data_d;

  logic                         grant_found;
  logic [IDX_W-1:0]             grant_idx;
  logic [IDX_W:0]               cand_sum;
  logic [IDX_W-1:0]             cand_idx;
  logic                         transfer;
  logic [IN_WL-1:0]             sel_a, sel_b;
  logic                         sel_op;

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(N_REQ))
        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      cand_idx = cand_sum[IDX_W-1:0];
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // One-hot grant, only while running and never during reset.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rstb && (state_q == RUN) && grant_found &&
                             (grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign transfer = |(req_valid & req_ready);

  // Select the granted requester's operands with constant-index slices.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a  = req_a[i*IN_WL +: IN_WL];
        sel_b  = req_b[i*IN_WL +: IN_WL];
        sel_op = req_add_nsub[i];
      end
    end
  end

  // Datapath operand registers, pointer advance, tag shift and response capture.
  always_comb begin
    dp_a_d    = transfer ? sel_a  : dp_a_q;
    dp_b_d    = transfer ? sel_b  : dp_b_q;
    dp_op_d   = transfer ? sel_op : dp_op_q;
    ptr_d     = ptr_q;
    if (transfer)
      ptr_d = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    tag_v_d   = {tag_v_q[DP_LAT-1:0], transfer};
    tag_idx_d = {tag_idx_q[DP_LAT-1:0], grant_idx};
    for (int i = 0; i < N_REQ; i++)
      rsp_valid_d[i] = tag_v_q[DP_LAT] && (tag_idx_q[DP_LAT] == IDX_W'(i));
    rsp_data_d = tag_v_q[DP_LAT] ? dp_r : rsp_data_q;
  end

  assign busy = |tag_v_q;

  // Flush FSM; drained_q remembers a completed drain while flush_req stays high.
  always_comb begin
    state_d   = state_q;
    drained_d = drained_q;
    case (state_q)
      RUN: begin
        drained_d = 1'b0;
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!busy && (!drained_q || !flush_req)) state_d = DONE;
      end
      DONE: begin
        if (flush_req) begin
          state_d   = DRAIN;
          drained_d = 1'b1;
        end else begin
          state_d   = RUN;
          drained_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= RUN;
      drained_q   <= 1'b0;
      ptr_q       <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_op_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drained_q   <= drained_d;
      ptr_q       <= ptr_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_op_q     <= dp_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign dp_a        = dp_a_q;
  assign dp_b        = dp_b_q;
  assign dp_add_nsub = dp_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign flush_done  = (state_q == DONE);

`ifdef ADDSUB_SCHED_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;

      // Saturating count of this requester's transfers.
      always_comb begin
        cnt_d = cnt_q;
        if (req_valid[gi] && req_ready[gi] && (cnt_q != 16'hFFFF))
          cnt_d = cnt_q + 16'd1;
      end

      // Counter register, cleared only by reset.
      always_ff @(posedge clk) begin
        if (!rstb) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign stat_grants[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_addsub_sched.sv
// Testbench for addsub_sched: table-driven single-request vectors, randomized
// traffic against a queue-based reference model, plus flush and mid-operation
// reset sequences. Also exercises stat_grants (macro ADDSUB_SCHED_STATS_EN).
`timescale 1ns/1ps

module tb_addsub_sched;
  localparam int N   = 4;
  localparam int IW  = 15;
  localparam int OW  = 16;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*IW-1:0]   req_a = '0;
  logic [N*IW-1:0]   req_b = '0;
  logic [N-1:0]      req_add_nsub = '0;
  logic [IW-1:0]     dp_a, dp_b;
  logic              dp_add_nsub;
  logic [OW-1:0]     dp_r;
  logic [N-1:0]      rsp_valid;
  logic [OW-1:0]     rsp_data;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic              busy;
  logic [N*16-1:0]   stat_grants;

  addsub_sched #(.N_REQ(N), .IN_WL(IW), .OUT_WL(OW), .DP_LAT(LAT)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_add_nsub(req_add_nsub),
    .dp_a(dp_a), .dp_b(dp_b), .dp_add_nsub(dp_add_nsub), .dp_r(dp_r),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy), .stat_grants(stat_grants)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] calc(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                         input logic op);
    logic [OW-1:0] ea, eb;
    ea = OW'(a);
    eb = OW'(b);
    return op ? (ea + eb) : (ea - eb);
  endfunction

  // External datapath: LAT register stages from dp_a/dp_b/dp_add_nsub to dp_r.
  logic [OW-1:0] dp_pipe [1:LAT];
  always @(posedge clk) begin
    dp_pipe[1] <= calc(dp_a, dp_b, dp_add_nsub);
    for (int k = 2; k <= LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_r = dp_pipe[LAT];

  typedef struct {
    int            idx;
    int            due;
    logic [OW-1:0] val;
  } exp_t;

  typedef struct {
    int            idx;
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic          op;
    logic [N-1:0]  ev;
    logic [OW-1:0] ed;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  logic          rv [N];
  logic [IW-1:0] ra [N];
  logic [IW-1:0] rb [N];
  logic          rop [N];
  int            gcount [N];
  int            ptr_m = 0;
  int            edge_n = 0;
  int            load_pct = 0;
  logic [N-1:0]  en_mask = '0;
  exp_t          sbq [$];
  logic [N-1:0]  obs_ready, obs_rv;
  logic [OW-1:0] obs_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, edge_n);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = rv[i];
      req_a[i*IW +: IW]   = ra[i];
      req_b[i*IW +: IW]   = rb[i];
      req_add_nsub[i]     = rop[i];
    end
  endfunction

  function automatic void new_op(input int i);
    rv[i]  = 1'b1;
    ra[i]  = IW'($urandom_range(0, (1 << IW) - 1));
    rb[i]  = IW'($urandom_range(0, (1 << IW) - 1));
    rop[i] = 1'($urandom_range(0, 1));
  endfunction

  function automatic logic idle();
    logic any;
    any = (sbq.size() != 0);
    for (int i = 0; i < N; i++) any = any | rv[i];
    return !any;
  endfunction

  // One clock: observe at negedge, compare with the model, advance requesters.
  task automatic cycle_check(input logic ready_en, input logic fd_exp);
    int            g;
    int            j;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_rv;
    logic [OW-1:0] exp_rd;
    logic          chk_data;
    @(negedge clk);
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_rd    = rsp_data;
    exp_rv    = '0;
    exp_rd    = '0;
    chk_data  = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == edge_n) begin
      exp_rv[sbq[0].idx] = 1'b1;
      exp_rd   = sbq[0].val;
      chk_data = 1'b1;
      void'(sbq.pop_front());
    end
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (chk_data) check("rsp_data", 64'(rsp_data), 64'(exp_rd));
    check("busy", 64'(busy), 64'(sbq.size() > 0));
    check("flush_done", 64'(flush_done), 64'(fd_exp));
    g = -1;
    if (ready_en) begin
      for (int k = 0; k < N; k++) begin
        j = (ptr_m + k) % N;
        if (g < 0 && rv[j]) g = j;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      sbq.push_back('{idx: g, due: edge_n + LAT + 2, val: calc(ra[g], rb[g], rop[g])});
      ptr_m = (g + 1) % N;
      if (gcount[g] < 65535) gcount[g]++;
    end
    @(posedge clk);
    edge_n++;
    #1;
    if (g >= 0) rv[g] = 1'b0;
    for (int i = 0; i < N; i++)
      if (!rv[i] && en_mask[i] && ($urandom_range(0, 99) < load_pct)) new_op(i);
    drive();
  endtask

  task automatic settle();
    en_mask  = '0;
    load_pct = 0;
    for (int k = 0; k < 40; k++) begin
      if (idle()) break;
      cycle_check(1'b1, 1'b0);
    end
    check("settle", 64'(idle()), 64'd1);
  endtask

  vec_t vt [6];
  int   f_edge, last_due, fd_edge, n_inflight, n_seen;
  logic got, fdx;

  initial begin
    vt[0] = '{idx: 2, a: 15'd5,      b: 15'd3,      op: 1'b1, ev: 4'b0100, ed: 16'h0008};
    vt[1] = '{idx: 1, a: 15'd0,      b: 15'd1,      op: 1'b0, ev: 4'b0010, ed: 16'hFFFF};
    vt[2] = '{idx: 0, a: 15'h7FFF,   b: 15'h7FFF,   op: 1'b1, ev: 4'b0001, ed: 16'hFFFE};
    vt[3] = '{idx: 3, a: 15'd0,      b: 15'h7FFF,   op: 1'b0, ev: 4'b1000, ed: 16'h8001};
    vt[4] = '{idx: 2, a: 15'h7FFF,   b: 15'd0,      op: 1'b0, ev: 4'b0100, ed: 16'h7FFF};
    vt[5] = '{idx: 0, a: 15'h1234,   b: 15'h0ABC,   op: 1'b1, ev: 4'b0001, ed: 16'h1CF0};

    // Reset with every requester asserting valid: nothing may be granted.
    for (int i = 0; i < N; i++) begin
      new_op(i);
      gcount[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_dp_a", 64'(dp_a), 64'd0);
    check("rst_dp_b", 64'(dp_b), 64'd0);
    check("rst_dp_add_nsub", 64'(dp_add_nsub), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stat_grants", stat_grants, 64'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    // All four valid continuously: grants 0,1,2,3,0 back to back.
    en_mask  = 4'hF;
    load_pct = 100;
    for (int s = 0; s < 5; s++) begin
      cycle_check(1'b1, 1'b0);
      check("rr_order", 64'(obs_ready), 64'(1 << (s % N)));
    end
    settle();

    // Single-request vectors with exact latency.
    foreach (vt[v]) begin
      rv[vt[v].idx]  = 1'b1;
      ra[vt[v].idx]  = vt[v].a;
      rb[vt[v].idx]  = vt[v].b;
      rop[vt[v].idx] = vt[v].op;
      drive();
      cycle_check(1'b1, 1'b0);
      check("vec_grant", 64'(obs_ready), 64'(vt[v].ev));
      repeat (LAT + 2) cycle_check(1'b1, 1'b0);
      check("vec_rsp_valid", 64'(obs_rv), 64'(vt[v].ev));
      check("vec_rsp_data", 64'(obs_rd), 64'(vt[v].ed));
      settle();
    end

    // Randomized traffic at several load levels.
    en_mask = 4'hF;
    load_pct = 60;  repeat (400) cycle_check(1'b1, 1'b0);
    load_pct = 100; repeat (200) cycle_check(1'b1, 1'b0);
    load_pct = 20;  repeat (300) cycle_check(1'b1, 1'b0);

    // Flush with operations in flight, held high past the first flush_done.
    load_pct = 100;
    repeat (5) cycle_check(1'b1, 1'b0);
    flush_req = 1'b1;
    cycle_check(1'b1, 1'b0);
    f_edge   = edge_n;
    last_due = f_edge;
    foreach (sbq[q]) if (sbq[q].due > last_due) last_due = sbq[q].due;
    fd_edge    = last_due + 1;
    n_inflight = sbq.size();
    n_seen     = 0;
    got        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      fdx = (edge_n == fd_edge);
      cycle_check(1'b0, fdx);
      if (obs_rv != '0) n_seen++;
      if (fdx) begin
        got = 1'b1;
        break;
      end
    end
    check("flush_reached", 64'(got), 64'd1);
    check("drain_rsp_count", 64'(n_seen), 64'(n_inflight));
    repeat (3) cycle_check(1'b0, 1'b0);
    flush_req = 1'b0;
    cycle_check(1'b0, 1'b0);
    cycle_check(1'b0, 1'b1);
    cycle_check(1'b1, 1'b0);
    check("grant_resumed", 64'(obs_ready != '0), 64'd1);

    // Reset for one edge with operations in flight.
    repeat (3) cycle_check(1'b1, 1'b0);
    @(negedge clk);
    rstb  = 1'b0;
    rv[0] = 1'b0;
    rv[2] = 1'b0;
    drive();
    #1;
    check("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk);
    edge_n++;
    #1;
    rstb = 1'b1;
    sbq.delete();
    ptr_m = 0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    en_mask  = '0;
    load_pct = 0;
    cycle_check(1'b1, 1'b0);
    check("rst_next_grant", 64'(obs_ready), 64'b0010);
    settle();

    en_mask  = 4'hF;
    load_pct = 70;
    repeat (200) cycle_check(1'b1, 1'b0);
    settle();

`ifdef ADDSUB_SCHED_STATS_EN
    for (int i = 0; i < N; i++)
      check("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(gcount[i]));
    en_mask  = 4'b0010;
    load_pct = 100;
    repeat (70000) cycle_check(1'b1, 1'b0);
    settle();
    check("stat_saturate", 64'(stat_grants[31:16]), 64'hFFFF);
`else
    check("stat_grants_zero", stat_grants, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_sched.md
ADDSUB_SCHED -- requirements
Module: addsub_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter IN_WL, default 15, operand width.
REQ-003 Parameter OUT_WL, default 16, result width.
REQ-004 Parameter DP_LAT, default 2, datapath register stages from dp_a/dp_b/dp_add_nsub to dp_r (1..4).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rstb  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-requester operation request.
REQ-008 req_ready  output  N_REQ  one-hot grant; a transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
REQ-009 req_a, req_b  input  N_REQ*IN_WL each  operands, requester i in bits [i*IN_WL +: IN_WL].
REQ-010 req_add_nsub  input  N_REQ  per-requester op; 1 is a+b, 0 is a-b.
REQ-011 dp_a, dp_b  output  IN_WL each  registered operands to the shared add/sub datapath.
REQ-012 dp_add_nsub  output  1  registered op select to datapath.
REQ-013 dp_r  input  OUT_WL  datapath result.
REQ-014 rsp_valid  output  N_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-015 rsp_data  output  OUT_WL  registered result, valid when any rsp_valid bit is high.
REQ-016 flush_req  input  1  level request to stop issuing and drain the datapath.
REQ-017 flush_done  output  1  one-cycle pulse when the drain completes.
REQ-018 busy  output  1  high while any issued operation has not yet produced rsp_valid.
REQ-019 stat_grants  output  N_REQ*16  per-requester grant counters (see Configuration).

Function
REQ-020 Arbitration SHALL be round-robin: search starts at index ptr, wraps modulo N_REQ; first valid requester is granted.
REQ-021 req_ready SHALL be combinational from req_valid, ptr and state, with at most one bit high, and only in state RUN.
REQ-022 After a transfer from requester i, ptr SHALL become (i+1) mod N_REQ; with no transfer ptr holds.
REQ-023 On a transfer edge, dp_a, dp_b, dp_add_nsub SHALL load the granted requester's fields; otherwise they hold.
REQ-024 The block SHALL accept one transfer per cycle with no bubbles while requests are pending in RUN.
REQ-025 A tag shift pipeline of DP_LAT+1 stages (valid bit + requester index) SHALL track every issued operation.
REQ-026 For a transfer on edge E, rsp_data SHALL capture dp_r on edge E+DP_LAT+1 and rsp_valid[i] SHALL be high for exactly the following cycle.
REQ-027 Results SHALL return in issue order; no response SHALL be dropped or duplicated; no response backpressure exists.
REQ-028 FSM states RUN, DRAIN, DONE; RUN->DRAIN when flush_req is high at an edge (a transfer on that same edge is still accepted).
REQ-029 In DRAIN no grants SHALL be issued; DRAIN->DONE on the edge after the tag pipeline becomes empty.
REQ-030 DONE SHALL last one cycle with flush_done high, then RUN if flush_req is low, else remain in DRAIN with nothing outstanding until flush_req falls (then RUN via DONE again).
REQ-031 busy SHALL equal the OR of all tag pipeline valid bits.
REQ-032 Requesters SHALL hold req_valid and operands stable until granted; the block relies on but does not check this.

Reset
REQ-033 While rstb is low at an edge: state=RUN, ptr=0, tag pipeline cleared, dp_a=dp_b=0, dp_add_nsub=0, rsp_valid=0, rsp_data=0, flush_done=0, stat counters=0.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL appear for them after rstb returns high.
REQ-035 req_ready SHALL be 0 during any cycle where rstb is low.

Configuration
REQ-036 Macro ADDSUB_SCHED_STATS_EN defined: stat_grants[i*16 +: 16] SHALL count transfers of requester i, saturating at 16'hFFFF, cleared by reset only.
REQ-037 Macro ADDSUB_SCHED_STATS_EN undefined: stat_grants SHALL be constant 0 and no counter logic SHALL be instantiated; all other behaviour identical.

Verification
REQ-038 Single request: req 2 valid, a=5, b=3, add_nsub=1, DP_LAT=2, transfer at edge 0 -> rsp_valid=4'b0100, rsp_data=8 in cycle after edge 3; busy high cycles 1..3.
REQ-039 All four valid continuously from reset -> grants 0,1,2,3,0 on consecutive edges; responses return in that order, one per cycle.
REQ-040 Subtract wrap: a=0, b=1, add_nsub=0 -> rsp_data equals datapath result 16'hFFFF, routed to the issuing requester only.
REQ-041 flush_req raised with 3 operations in flight -> no req_ready while draining; 3 responses delivered; flush_done single pulse on the cycle after last rsp_valid; grants resume after flush_req falls.
REQ-042 rstb low for one edge while 2 operations in flight -> no rsp_valid afterwards, ptr=0, next grant goes to lowest valid index.
REQ-043 With ADDSUB_SCHED_STATS_EN: 70000 grants to requester 1 -> stat_grants[31:16]=16'hFFFF; without macro -> stat_grants stays 0.
